// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the external memory port arbiter (mem_port_arb).
package mem_arb_pkg;

  localparam int ADDR_W = 23;

  typedef enum logic [1:0] {
    REQ_CPU = 2'd0,
    REQ_PPU = 2'd1,
    REQ_DMA = 2'd2
  } req_id_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  function automatic req_id_e grant_to_id(input logic [2:0] grant);
    if (grant[REQ_DMA]) return REQ_DMA;
    if (grant[REQ_PPU]) return REQ_PPU;
    return REQ_CPU;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: CPU > PPU > DMA, unless a promoted DMA request jumps the queue.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       cpu_req_i,
  input  logic       ppu_req_i,
  input  logic       dma_req_i,
  input  logic       promote_i,
  output logic [2:0] grant_o
);

  always_comb begin
    grant_o = '0;
    if (dma_req_i && promote_i) begin
      grant_o[REQ_DMA] = 1'b1;
    end else if (cpu_req_i) begin
      grant_o[REQ_CPU] = 1'b1;
    end else if (ppu_req_i) begin
      grant_o[REQ_PPU] = 1'b1;
    end else if (dma_req_i) begin
      grant_o[REQ_DMA] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// Three-requester external memory port arbiter with fixed-length accesses (IDLE/ACCESS/DONE).
// Define MEM_PORT_ARB_STARVE_GUARD_EN to promote a starved DMA request after STARVE_MAX grants.
module mem_port_arb
  import mem_arb_pkg::*;
#(
  parameter int ACC_CYC    = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_di,
  output logic [7:0]        cpu_do,
  output logic              cpu_ack,

  input  logic              ppu_req,
  input  logic              ppu_we,
  input  logic [ADDR_W-1:0] ppu_addr,
  input  logic [7:0]        ppu_di,
  output logic [7:0]        ppu_do,
  output logic              ppu_ack,

  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_di,
  output logic [7:0]        dma_do,
  output logic              dma_ack,

  output logic              mem_ce,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_dati,
  input  logic [7:0]        mem_dato
);

  localparam logic [3:0] CntLoad = 4'(ACC_CYC - 1);

  if (ACC_CYC < 1 || ACC_CYC > 15 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_param_check
    $error("mem_port_arb: ACC_CYC and STARVE_MAX must lie in 1..15");
  end

  arb_state_e        state_q;
  req_id_e           owner_q;
  logic [3:0]        cnt_q;
  logic              mem_ce_q, mem_oe_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_dati_q;
  logic [7:0]        cpu_do_q, ppu_do_q, dma_do_q;
  logic              cpu_ack_q, ppu_ack_q, dma_ack_q;

  logic              any_req;
  logic              promote;
  logic [2:0]        grant;
  req_id_e           win_id_d;
  logic              win_we_d;
  logic [ADDR_W-1:0] win_addr_d;
  logic [7:0]        win_di_d;

  assign any_req = cpu_req | ppu_req | dma_req;

  mem_arb_pick u_pick (
    .cpu_req_i (cpu_req),
    .ppu_req_i (ppu_req),
    .dma_req_i (dma_req),
    .promote_i (promote),
    .grant_o   (grant)
  );

  always_comb begin
    win_id_d   = grant_to_id(grant);
    win_we_d   = cpu_we;
    win_addr_d = cpu_addr;
    win_di_d   = cpu_di;
    case (win_id_d)
      REQ_PPU: begin
        win_we_d   = ppu_we;
        win_addr_d = ppu_addr;
        win_di_d   = ppu_di;
      end
      REQ_DMA: begin
        win_we_d   = dma_we;
        win_addr_d = dma_addr;
        win_di_d   = dma_di;
      end
      default: ;
    endcase
  end

`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
  logic [3:0] starve_q, starve_d;

  // Only grants made while DMA is waiting count against it; any other grant resets the tally.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE && any_req) begin
      if (grant[REQ_DMA] || !dma_req) begin
        starve_d = '0;
      end else if (starve_q != 4'hF) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end

  assign promote = dma_req && (starve_q == 4'(STARVE_MAX));
`else
  assign promote = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= REQ_CPU;
      cnt_q      <= '0;
      mem_ce_q   <= 1'b0;
      mem_oe_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_dati_q <= '0;
      cpu_do_q   <= '0;
      ppu_do_q   <= '0;
      dma_do_q   <= '0;
      cpu_ack_q  <= 1'b0;
      ppu_ack_q  <= 1'b0;
      dma_ack_q  <= 1'b0;
    end else begin
      cpu_ack_q <= 1'b0;
      ppu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q    <= win_id_d;
            mem_addr_q <= win_addr_d;
            mem_dati_q <= win_di_d;
            cnt_q      <= CntLoad;
            mem_ce_q   <= 1'b1;
            mem_oe_q   <= !win_we_d;
            mem_we_q   <= win_we_d;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          // mem_we_q still holds the access direction on the final cycle.
          if (cnt_q == 4'd0) begin
            mem_ce_q <= 1'b0;
            mem_oe_q <= 1'b0;
            mem_we_q <= 1'b0;
            state_q  <= DONE;
            case (owner_q)
              REQ_PPU: begin
                ppu_ack_q <= 1'b1;
                if (!mem_we_q) ppu_do_q <= mem_dato;
              end
              REQ_DMA: begin
                dma_ack_q <= 1'b1;
                if (!mem_we_q) dma_do_q <= mem_dato;
              end
              default: begin
                cpu_ack_q <= 1'b1;
                if (!mem_we_q) cpu_do_q <= mem_dato;
              end
            endcase
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_ce   = mem_ce_q;
  assign mem_oe   = mem_oe_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_dati = mem_dati_q;
  assign cpu_do   = cpu_do_q;
  assign ppu_do   = ppu_do_q;
  assign dma_do   = dma_do_q;
  assign cpu_ack  = cpu_ack_q;
  assign ppu_ack  = ppu_ack_q;
  assign dma_ack  = dma_ack_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: vector table, corner-case sequences and random traffic
// compared every cycle against a transaction-phase reference model.
module tb_mem_port_arb;
  import mem_arb_pkg::*;

  localparam int ACC  = 4;
  localparam int SMAX = 8;

  typedef struct {
    int          id;
    logic        we;
    logic [22:0] addr;
    logic [7:0]  di;
    logic [7:0]  dato;
    int          expOe;
    int          expWe;
    int          expLat;
    logic [7:0]  expDo;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rq [3];
  logic        wr [3];
  logic [22:0] ad [3];
  logic [7:0]  di [3];
  logic [7:0]  doV [3];
  logic        ackV [3];
  logic [7:0]  cpuDo, ppuDo, dmaDo;
  logic        cpuAck, ppuAck, dmaAck;
  logic        memCe, memOe, memWe;
  logic [22:0] memAddr;
  logic [7:0]  memDati, memDato;

  int checks = 0;
  int failures = 0;

  // Reference model: an access is a phase count 1..ACC (strobes) followed by ACC+1 (ack).
  bit          mBusy;
  int          mPhase, mOwner, mStarve;
  logic        mWe;
  logic [22:0] mAddr;
  logic [7:0]  mDi;
  logic [7:0]  mDo [3];

  always #5 clk = ~clk;

  assign doV[0]  = cpuDo;
  assign doV[1]  = ppuDo;
  assign doV[2]  = dmaDo;
  assign ackV[0] = cpuAck;
  assign ackV[1] = ppuAck;
  assign ackV[2] = dmaAck;

  mem_port_arb #(.ACC_CYC(ACC), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(rq[0]), .cpu_we(wr[0]), .cpu_addr(ad[0]), .cpu_di(di[0]), .cpu_do(cpuDo), .cpu_ack(cpuAck),
    .ppu_req(rq[1]), .ppu_we(wr[1]), .ppu_addr(ad[1]), .ppu_di(di[1]), .ppu_do(ppuDo), .ppu_ack(ppuAck),
    .dma_req(rq[2]), .dma_we(wr[2]), .dma_addr(ad[2]), .dma_di(di[2]), .dma_do(dmaDo), .dma_ack(dmaAck),
    .mem_ce(memCe), .mem_oe(memOe), .mem_we(memWe),
    .mem_addr(memAddr), .mem_dati(memDati), .mem_dato(memDato)
  );

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit modelAck(input int i);
    return mBusy && (mPhase == ACC + 1) && (mOwner == i);
  endfunction

  task automatic modelReset();
    mBusy = 0; mPhase = 0; mOwner = 0; mStarve = 0;
    mWe = 0; mAddr = '0; mDi = '0;
    for (int i = 0; i < 3; i++) mDo[i] = 8'h00;
  endtask

  // Advances the model across one rising edge, using the inputs currently driven.
  task automatic modelStep();
    bit guard;
    int w;
`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
    guard = 1;
`else
    guard = 0;
`endif
    if (mBusy) begin
      if (mPhase == ACC + 1) mBusy = 0;
      else begin
        if (mPhase == ACC && !mWe) mDo[mOwner] = memDato;
        mPhase++;
      end
    end else if (rq[0] || rq[1] || rq[2]) begin
      if (guard && rq[2] && mStarve == SMAX) w = 2;
      else if (rq[0]) w = 0;
      else if (rq[1]) w = 1;
      else w = 2;
      if (guard) begin
        if (w == 2 || !rq[2]) mStarve = 0;
        else if (mStarve < 15) mStarve++;
      end
      mBusy = 1; mPhase = 1; mOwner = w;
      mWe = wr[w]; mAddr = ad[w]; mDi = di[w];
    end
  endtask

  task automatic applyStimulus(input int i, input logic r, input logic w,
                               input logic [22:0] a, input logic [7:0] d);
    rq[i] = r; wr[i] = w; ad[i] = a; di[i] = d;
  endtask

  task automatic checkOutput();
    logic ce;
    ce = mBusy && (mPhase <= ACC);
    checkVal("mem_ce", memCe, ce);
    checkVal("mem_oe", memOe, ce && !mWe);
    checkVal("mem_we", memWe, ce && mWe);
    for (int i = 0; i < 3; i++) begin
      checkVal($sformatf("ack%0d", i), ackV[i], modelAck(i));
      checkVal($sformatf("do%0d", i), doV[i], mDo[i]);
    end
    if (ce) begin
      checkVal("mem_addr", memAddr, mAddr);
      checkVal("mem_dati", memDati, mDi);
    end
  endtask

  task automatic cycle();
    if (rst_n) modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic runVector(input vec_t v, input string tag);
    int oeN, weN, lat;
    oeN = 0; weN = 0; lat = 0;
    memDato = v.dato;
    applyStimulus(v.id, 1'b1, v.we, v.addr, v.di);
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      cycle();
      if (memOe) oeN++;
      if (memWe) weN++;
      if (ackV[v.id]) begin
        lat = n;
        rq[v.id] = 1'b0;
      end
    end
    checkVal({tag, "_oe_cycles"}, oeN, v.expOe);
    checkVal({tag, "_we_cycles"}, weN, v.expWe);
    checkVal({tag, "_ack_latency"}, lat, v.expLat);
    checkVal({tag, "_do"}, doV[v.id], v.expDo);
    cycle();
  endtask

  initial begin
    vec_t vecs [6];
    vec_t fresh;
    int ackAt [3];
    int nAck, ceRises, cnt, cpuAcks, dmaAfter;
    logic prevCe;

    vecs[0] = '{0, 1'b0, 23'h000123, 8'h00, 8'hA5, 4, 0, 5, 8'hA5};
    vecs[1] = '{1, 1'b0, 23'h400010, 8'h00, 8'h3C, 4, 0, 5, 8'h3C};
    vecs[2] = '{2, 1'b1, 23'h7FFFFF, 8'h5C, 8'hEE, 0, 4, 5, 8'h00};
    vecs[3] = '{0, 1'b1, 23'h000000, 8'hFF, 8'h12, 0, 4, 5, 8'hA5};
    vecs[4] = '{2, 1'b0, 23'h000001, 8'h00, 8'h81, 4, 0, 5, 8'h81};
    vecs[5] = '{1, 1'b1, 23'h123456, 8'h77, 8'h99, 0, 4, 5, 8'h3C};

    rst_n = 1'b0;
    memDato = 8'h00;
    for (int i = 0; i < 3; i++) applyStimulus(i, 1'b0, 1'b0, 23'h0, 8'h00);
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput();
    checkVal("reset_mem_addr", memAddr, 0);
    checkVal("reset_mem_dati", memDati, 0);
    rst_n = 1'b1;
    cycle();
    cycle();

    for (int k = 0; k < 6; k++) runVector(vecs[k], $sformatf("vec%0d", k));

    // All three requesters raised together: one grant at a time, acks 6 cycles apart.
    ackAt = '{0, 0, 0};
    nAck = 0; ceRises = 0; prevCe = 1'b0;
    memDato = 8'h11;
    applyStimulus(0, 1'b1, 1'b0, 23'h000200, 8'h01);
    applyStimulus(1, 1'b1, 1'b1, 23'h200300, 8'h02);
    applyStimulus(2, 1'b1, 1'b0, 23'h300400, 8'h03);
    for (int n = 1; n <= 30 && nAck < 3; n++) begin
      cycle();
      if (memCe && !prevCe) ceRises++;
      prevCe = memCe;
      for (int i = 0; i < 3; i++) if (ackV[i]) begin
        ackAt[i] = n; nAck++; rq[i] = 1'b0;
      end
    end
    checkVal("3way_cpu_ack_cycle", ackAt[0], 5);
    checkVal("3way_ppu_ack_cycle", ackAt[1], 11);
    checkVal("3way_dma_ack_cycle", ackAt[2], 17);
    checkVal("3way_mem_accesses", ceRises, 3);
    cycle();

    // PPU drops its request right after being granted; the access must still finish.
    memDato = 8'h6B;
    applyStimulus(1, 1'b1, 1'b0, 23'h055555, 8'h00);
    cycle();
    rq[1] = 1'b0;
    cnt = 0;
    for (int n = 0; n < 12; n++) begin
      cycle();
      if (ackV[1]) cnt++;
    end
    checkVal("ppu_drop_ack_count", cnt, 1);
    checkVal("ppu_drop_do", ppuDo, 8'h6B);

    // Reset pulsed during the second ACCESS cycle of a DMA write.
    applyStimulus(2, 1'b1, 1'b1, 23'h7FFFFF, 8'h5C);
    cycle();
    cycle();
    #2 rst_n = 1'b0;
    rq[2] = 1'b0;
    #1;
    checkVal("rst_mid_mem_we", memWe, 0);
    checkVal("rst_mid_mem_ce", memCe, 0);
    checkVal("rst_mid_mem_addr", memAddr, 0);
    modelReset();
    cycle();
    rst_n = 1'b1;
    cnt = 0;
    for (int n = 0; n < 8; n++) begin
      cycle();
      if (ackV[2]) cnt++;
    end
    checkVal("rst_mid_no_dma_ack", cnt, 0);
    fresh = '{2, 1'b1, 23'h7FFFFF, 8'h5C, 8'h00, 0, 4, 5, 8'h00};
    runVector(fresh, "rst_fresh");

    // CPU hogs the port while DMA waits.
    applyStimulus(0, 1'b1, 1'b0, 23'h000010, 8'h00);
    applyStimulus(2, 1'b1, 1'b1, 23'h000020, 8'hD0);
`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
    for (int round = 0; round < 2; round++) begin
      cpuAcks = 0; dmaAfter = -1;
      for (int n = 0; n < 200 && dmaAfter < 0; n++) begin
        cycle();
        if (ackV[0]) cpuAcks++;
        if (ackV[2]) dmaAfter = cpuAcks;
      end
      checkVal($sformatf("starve_round%0d_cpu_acks_before_dma", round), dmaAfter, SMAX);
    end
`else
    cpuAcks = 0; cnt = 0;
    for (int n = 1; n <= 100; n++) begin
      cycle();
      if (ackV[0]) cpuAcks++;
      if (ackV[2]) cnt++;
    end
    checkVal("fixed_prio_dma_acks", cnt, 0);
    checkVal("fixed_prio_cpu_acks", cpuAcks, 16);
`endif
    for (int i = 0; i < 3; i++) rq[i] = 1'b0;
    repeat (8) cycle();

    // Random traffic: requests hold until acked, then may drop or repeat.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 3; i++)
        if (!rq[i] && $urandom_range(3) == 0)
          applyStimulus(i, 1'b1, 1'($urandom_range(1)), 23'($urandom), 8'($urandom));
      memDato = 8'($urandom);
      cycle();
      for (int i = 0; i < 3; i++)
        if (modelAck(i) && $urandom_range(1) == 1) rq[i] = 1'b0;
    end
    for (int i = 0; i < 3; i++) rq[i] = 1'b0;
    repeat (8) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time=%0t limit=%0t", $time, 1000000);
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
